// File: rtl/ucdp_sync_hs_tx_pkg.sv
// Shared types and constants for the toggle-handshake CDC transmitter.
package ucdp_sync_hs_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned min_stages_p = 2;
  localparam int unsigned cnt_width_p  = 16;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [cnt_width_p-1:0] sat_inc(
    input logic [cnt_width_p-1:0] value,
    input logic [cnt_width_p-1:0] limit
  );
    logic [cnt_width_p-1:0] res;
    if (value >= limit) begin
      res = value;
    end else begin
      res = value + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ucdp_sync_hs_tx_chain.sv
// Multi-flop synchronizer for a single asynchronous toggle.
// Flops clear synchronously so a reset also discards any toggle in flight.
module ucdp_sync_hs_tx_chain
  import ucdp_sync_hs_tx_pkg::*;
#(
  parameter int unsigned stages_p = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  if (stages_p < min_stages_p) begin : g_bad_stages
    $error("ucdp_sync_hs_tx_chain: stages_p must be at least 2");
  end

  // First stage is the metastability catcher for the remote ack toggle.
  (* async_reg = "true", cdc_waiver = "toggle from remote clock domain" *)
  logic                  first_r;
  logic [stages_p-1:1]   rest_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_r <= 1'b0;
      rest_r  <= '0;
    end else begin
      first_r   <= d_i;
      rest_r[1] <= first_r;
      for (int i = 2; i < int'(stages_p); i++) begin
        rest_r[i] <= rest_r[i-1];
      end
    end
  end

  assign q_o = rest_r[stages_p-1];

endmodule

// File: rtl/ucdp_sync_hs_tx.sv
// Source half of a toggle-handshake clock-domain crossing.
// A word accepted on valid/ready is held on tx_data_o and announced by a
// req_o toggle; the synchronized ack toggle re-opens the block.
// Optional overdue-ack indication: define UCDP_SYNC_HS_TX_TIMEOUT_EN.
module ucdp_sync_hs_tx
  import ucdp_sync_hs_tx_pkg::*;
#(
  parameter int unsigned width_p   = 8,
  parameter int unsigned stages_p  = 2,
  parameter int unsigned timeout_p = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               req_o,
  output logic [width_p-1:0] tx_data_o,
  input  logic               ack_i,
  output logic               proto_err_o,
  output logic               timeout_o
);

  if ((width_p < 1) || (width_p > 64)) begin : g_bad_width
    $error("ucdp_sync_hs_tx: width_p must be within 1..64");
  end
  if ((timeout_p < 1) || (timeout_p > 65535)) begin : g_bad_timeout
    $error("ucdp_sync_hs_tx: timeout_p must be within 1..65535");
  end

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               ack_s;
  logic               ack_last_r;
  logic               ack_edge_s;
  logic               ready_r;
  logic               req_r;
  logic [width_p-1:0] data_r;
  logic               proto_err_r;
  logic               timeout_r;

  ucdp_sync_hs_tx_chain #(
    .stages_p (stages_p)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  // Remember the previous synchronized ack level for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_last_r <= 1'b0;
    end else begin
      ack_last_r <= ack_s;
    end
  end

  assign ack_edge_s = ack_s ^ ack_last_r;

  // Next-state and accept decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid_i) begin
          accept_s    = 1'b1;
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (ack_edge_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, handshake outputs and the held data word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      ready_r     <= 1'b1;
      req_r       <= 1'b0;
      data_r      <= '0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ready_r     <= (state_nxt_s == IDLE);
      proto_err_r <= ack_edge_s & (state_r == IDLE);
      if (accept_s) begin
        req_r  <= ~req_r;
        data_r <= data_i;
      end else begin
        req_r  <= req_r;
        data_r <= data_r;
      end
    end
  end

`ifdef UCDP_SYNC_HS_TX_TIMEOUT_EN
  localparam logic [cnt_width_p-1:0] timeout_lp = cnt_width_p'(timeout_p);

  logic [cnt_width_p-1:0] cnt_r;
  logic [cnt_width_p-1:0] cnt_nxt_s;

  // Count BUSY cycles from zero on entry, sticking at the limit.
  always_comb begin
    cnt_nxt_s = '0;
    if (state_r == BUSY) begin
      cnt_nxt_s = sat_inc(cnt_r, timeout_lp);
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Register the count and flag the overdue ack while still BUSY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      timeout_r <= (state_r == BUSY) && (state_nxt_s == BUSY) &&
                   (cnt_nxt_s == timeout_lp);
    end
  end
`else
  assign timeout_r = 1'b0;
`endif

  assign ready_o     = ready_r;
  assign req_o       = req_r;
  assign tx_data_o   = data_r;
  assign proto_err_o = proto_err_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_ucdp_sync_hs_tx.sv
// Directed, table-driven bench for ucdp_sync_hs_tx (width 8, 2 sync stages).
module tb_ucdp_sync_hs_tx;

`ifdef UCDP_SYNC_HS_TX_TIMEOUT_EN
  localparam int unsigned TO_P  = 5;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO_P  = 1024;
  localparam bit          TO_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       req_o;
  logic [7:0] tx_data_o;
  logic       ack_i;
  logic       proto_err_o;
  logic       timeout_o;

  logic       ack_drv;
  logic       echo_en;
  logic       echo_ack;
  logic       req_seen;
  int         dly;
  logic [7:0] rx_q[$];

  int errors = 0;
  int checks = 0;

  ucdp_sync_hs_tx #(
    .width_p   (8),
    .stages_p  (2),
    .timeout_p (TO_P)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .req_o       (req_o),
    .tx_data_o   (tx_data_o),
    .ack_i       (ack_i),
    .proto_err_o (proto_err_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  assign ack_i = echo_en ? echo_ack : ack_drv;

  // Remote receiver model: capture word on each req toggle, echo ack 3 cycles later.
  always @(negedge clk_i) begin
    if (!echo_en) begin
      req_seen <= req_o;
      echo_ack <= ack_drv;
      dly      <= 0;
    end else if (req_o != req_seen) begin
      rx_q.push_back(tx_data_o);
      req_seen <= req_o;
      dly      <= 3;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) echo_ack <= ~echo_ack;
    end
  end

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       e_ready;
    logic       e_req;
    logic [7:0] e_data;
    logic       e_perr;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int t;
    t = 0;
    while (!ready_o && t < 50) begin
      step();
      t++;
    end
    chk({nm, "_ready_wait"}, {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst, valid, data, ack | ready, req, data, perr
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    echo_en = 1'b0;
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'hFF;
    ack_drv = 1'b1;

    // Reset with busy-looking inputs must leave the idle state.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d_ready", i), {63'd0, ready_o}, 64'd1);
      chk($sformatf("rst%0d_req", i), {63'd0, req_o}, 64'd0);
      chk($sformatf("rst%0d_data", i), {56'd0, tx_data_o}, 64'd0);
      chk($sformatf("rst%0d_perr", i), {63'd0, proto_err_o}, 64'd0);
      chk($sformatf("rst%0d_tout", i), {63'd0, timeout_o}, 64'd0);
    end
    valid_i = 1'b0;
    ack_drv = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    step();
    chk("idle_perr", {63'd0, proto_err_o}, 64'd0);

    // Table: single transfer, hold while busy, spurious ack, reset mid-BUSY.
    for (int i = 0; i < 21; i++) begin
      rst_i   = vecs[i].rst;
      valid_i = vecs[i].valid;
      data_i  = vecs[i].data;
      ack_drv = vecs[i].ack;
      step();
      chk($sformatf("v%0d_ready", i), {63'd0, ready_o}, {63'd0, vecs[i].e_ready});
      chk($sformatf("v%0d_req", i), {63'd0, req_o}, {63'd0, vecs[i].e_req});
      chk($sformatf("v%0d_data", i), {56'd0, tx_data_o}, {56'd0, vecs[i].e_data});
      chk($sformatf("v%0d_perr", i), {63'd0, proto_err_o}, {63'd0, vecs[i].e_perr});
      chk($sformatf("v%0d_tout", i), {63'd0, timeout_o}, 64'd0);
    end
    rst_i   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;

    // Back-to-back words against the echoing receiver.
    echo_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_ready($sformatf("b2b%0d", k));
      valid_i = 1'b1;
      data_i  = 8'(k);
      step();
      valid_i = 1'b0;
      chk($sformatf("b2b%0d_req", k), {63'd0, req_o}, {63'd0, (k % 2) == 1});
      chk($sformatf("b2b%0d_data", k), {56'd0, tx_data_o}, 64'(k));
      chk($sformatf("b2b%0d_ready", k), {63'd0, ready_o}, 64'd0);
    end
    wait_ready("b2b_end");
    step();
    ack_drv = echo_ack;
    echo_en = 1'b0;
    chk("b2b_count", 64'(rx_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < rx_q.size()) begin
        chk($sformatf("b2b_rx%0d", k), {56'd0, rx_q[k]}, 64'(k + 1));
      end else begin
        chk($sformatf("b2b_rx%0d_missing", k), 64'd0, 64'd1);
      end
    end
    chk("b2b_perr", {63'd0, proto_err_o}, 64'd0);

    // Withheld ack: timeout indication (constant 0 without the feature).
    step();
    valid_i = 1'b1;
    data_i  = 8'hC3;
    step();
    valid_i = 1'b0;
    chk("to_req", {63'd0, req_o}, 64'd1);
    chk("to_data", {56'd0, tx_data_o}, 64'hC3);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("to_c%0d", k), {63'd0, timeout_o}, {63'd0, TO_EN && (k >= 5)});
      chk($sformatf("to_c%0d_ready", k), {63'd0, ready_o}, 64'd0);
    end
    ack_drv = ~ack_drv;
    step();
    step();
    chk("to_hold", {63'd0, timeout_o}, {63'd0, TO_EN});
    step();
    chk("to_clear", {63'd0, timeout_o}, 64'd0);
    chk("to_ready", {63'd0, ready_o}, 64'd1);
    chk("to_perr", {63'd0, proto_err_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
